addsub_accum_mc: RTL

Multi-channel add/subtract accumulator with per-transaction opcode, optional signed saturation and valid/ready flow control on both sides. It keeps `Channels` independent running sums of `Width` bits. Each accepted input updates one channel and returns that channel's new value with signed-overflow and carry flags. It is the parametrised successor to the single-channel add-only accumulator and sits between the operand source and result consumer in the datapath.

---
 rtl/addsub_accum_mc.sv | 108 ++++++++++
 1 files changed

// File: rtl/addsub_accum_mc.sv
// rtl/addsub_accum_mc.sv - multi-channel add/sub/load/clear accumulator with valid/ready and optional saturation
module addsub_accum_mc #(
    parameter int Width    = 8,
    parameter int Channels = 4,
    parameter bit Saturate = 1'b0,
    localparam int ChW     = (Channels > 1) ? $clog2(Channels) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ChW-1:0]   in_ch,
    input  logic [1:0]       in_op,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ChW-1:0]   out_ch,
    output logic [Width-1:0] out_sum,
    output logic             out_overflow,
    output logic             out_carry
);

    localparam logic [1:0] OpAdd   = 2'b00;
    localparam logic [1:0] OpSub   = 2'b01;
    localparam logic [1:0] OpLoad  = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    localparam logic [ChW:0]     ChLimit = (ChW + 1)'(Channels);
    localparam logic [Width-1:0] SatMax  = {1'b0, {(Width - 1){1'b1}}};
    localparam logic [Width-1:0] SatMin  = {1'b1, {(Width - 1){1'b0}}};

    logic [Width-1:0] r_acc [Channels];
    logic             r_out_valid;
    logic [ChW-1:0]   r_out_ch;
    logic [Width-1:0] r_out_sum;
    logic             r_out_overflow;
    logic             r_out_carry;

    logic             w_accept;
    logic             w_ch_ok;
    logic             w_sub;
    logic [Width-1:0] w_acc;
    logic [Width-1:0] w_opb;
    logic [Width:0]   w_sum_ext;
    logic             w_ovf_raw;
    logic [Width-1:0] w_val;
    logic             w_ovf;
    logic             w_cy;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    // Out-of-range channels (non-power-of-2 Channels) are accepted but dropped.
    assign w_ch_ok  = ({1'b0, in_ch} < ChLimit);

    always_comb begin
        w_acc     = w_ch_ok ? r_acc[in_ch] : '0;
        w_sub     = (in_op == OpSub);
        w_opb     = w_sub ? ~in_data : in_data;
        w_sum_ext = {1'b0, w_acc} + {1'b0, w_opb} + {{Width{1'b0}}, w_sub};
        w_ovf_raw = (w_acc[Width-1] == w_opb[Width-1]) && (w_sum_ext[Width-1] != w_acc[Width-1]);
        w_val     = '0;
        w_ovf     = 1'b0;
        w_cy      = 1'b0;
        case (in_op)
            OpAdd, OpSub: begin
                w_val = w_sum_ext[Width-1:0];
                w_ovf = w_ovf_raw;
                w_cy  = w_sum_ext[Width];
                // On overflow both operands share the accumulator's sign, so it gives the true sign.
                if (Saturate && w_ovf_raw) begin
                    w_val = w_acc[Width-1] ? SatMin : SatMax;
                end
            end
            OpLoad:  w_val = in_data;
            OpClear: w_val = '0;
            default: w_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Channels; i++) begin
                r_acc[i] <= '0;
            end
            r_out_valid    <= 1'b0;
            r_out_ch       <= '0;
            r_out_sum      <= '0;
            r_out_overflow <= 1'b0;
            r_out_carry    <= 1'b0;
        end else if (w_accept && w_ch_ok) begin
            r_acc[in_ch]   <= w_val;
            r_out_valid    <= 1'b1;
            r_out_ch       <= in_ch;
            r_out_sum      <= w_val;
            r_out_overflow <= w_ovf;
            r_out_carry    <= w_cy;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_ch       = r_out_ch;
    assign out_sum      = r_out_sum;
    assign out_overflow = r_out_overflow;
    assign out_carry    = r_out_carry;

endmodule
